// File: rtl/frame_writer.sv
// frame_writer: fills the back buffer from a multi-frame sprite ROM and requests a swap on vsync
module frame_writer #(
  parameter int COLS       = 32,
  parameter int ROWS       = 24,
  parameter int FRAMES     = 4,
  parameter int FRAME_HOLD = 15,
  parameter int ROM_AW     = 12,
  parameter int WR_AW      = 19
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         vsync,
  input  logic                                         pause,
  output logic [ROM_AW-1:0]                            rom_addr,
  input  logic [7:0]                                   rom_data,
  output logic                                         write_en,
  output logic [WR_AW-1:0]                             write_addr,
  output logic [7:0]                                   pixel_data_in,
  output logic                                         swap,
  output logic [(FRAMES > 1 ? $clog2(FRAMES) : 1)-1:0] frame_idx,
  output logic                                         busy
);
  localparam int NPIX = COLS * ROWS;
  localparam int PW   = $clog2(NPIX);
  localparam int FW   = FRAMES > 1 ? $clog2(FRAMES) : 1;
  localparam int VW   = $clog2(FRAME_HOLD + 1);
  localparam logic [ROM_AW-1:0] FSZ = ROM_AW'(NPIX);
  typedef enum logic {FILL, WAIT_VS} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic              drain_q, drain_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [VW-1:0]     vs_cnt_q, vs_cnt_d;
  logic              we_q, we_d, swap_q, swap_d, busy_q, busy_d;
  logic [WR_AW-1:0]  wa_q, wa_d;
  logic [2:0]        sync_q, sync_d;
  logic              vs_edge;
  assign vs_edge       = sync_q[2] & ~sync_q[1];
  assign rom_addr      = ROM_AW'(frame_q) * FSZ + ROM_AW'(pix_q);
  assign write_en      = we_q;
  assign write_addr    = wa_q;
  assign pixel_data_in = we_q ? rom_data : 8'd0;
  assign swap          = swap_q;
  assign frame_idx     = frame_q;
  assign busy          = busy_q;
  always_comb begin
    sync_d   = {sync_q[1:0], vsync};
    state_d  = state_q;
    pix_d    = pix_q;
    drain_d  = drain_q;
    frame_d  = frame_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    swap_d   = 1'b0;
    vs_cnt_d = (vs_edge && vs_cnt_q != VW'(FRAME_HOLD)) ? vs_cnt_q + VW'(1) : vs_cnt_q;
    if (state_q == FILL) begin
      // the address issued last cycle is written now; the drain cycle only finishes that write
      we_d    = ~drain_q;
      wa_d    = WR_AW'(pix_q);
      drain_d = ~drain_q && pix_q == PW'(NPIX - 1);
      pix_d   = (drain_q || pix_q == PW'(NPIX - 1)) ? pix_q : pix_q + PW'(1);
      state_d = drain_q ? WAIT_VS : FILL;
    end else if (vs_edge && vs_cnt_q >= VW'(FRAME_HOLD - 1) && !pause) begin
      swap_d   = 1'b1;
      frame_d  = frame_q == FW'(FRAMES - 1) ? '0 : frame_q + FW'(1);
      pix_d    = '0;
      vs_cnt_d = '0;
      state_d  = FILL;
    end
    busy_d = state_d == FILL;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      pix_q    <= '0;
      drain_q  <= 1'b0;
      frame_q  <= '0;
      vs_cnt_q <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      swap_q   <= 1'b0;
      busy_q   <= 1'b0;
      sync_q   <= '1;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      drain_q  <= drain_d;
      frame_q  <= frame_d;
      vs_cnt_q <= vs_cnt_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      swap_q   <= swap_d;
      busy_q   <= busy_d;
      sync_q   <= sync_d;
    end
  end
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed checks of fill, vsync-gated swap, pause, reset and drain-edge behaviour
module tb_frame_writer;
  logic clk = 1'b0, rst = 1'b0, vs_a = 1'b1, vs_b = 1'b1, pause = 1'b0;
  logic [11:0] rom_addr_a, rom_addr_b;
  logic [7:0]  rom_data_a, rom_data_b, pix_a, pix_b;
  logic [18:0] wa_a, wa_b;
  logic [1:0]  frame_a, frame_b;
  logic        we_a, we_b, swap_a, swap_b, busy_a, busy_b;
  int cmp = 0, errs = 0;
  int wr_a = 0, fill_wr_a = 0, swap_a_cnt = 0, swap_b_cnt = 0, seq_err_a = 0, both_a = 0, wide_a = 0;
  int max_rom_a = 0, first_rom_a = -1, last_rom_a = -1, exp_wa_a = 0;
  logic swap_prev_a = 1'b0;

  always #5 clk = ~clk;

  frame_writer #(.FRAME_HOLD(15)) u_a (
    .clk(clk), .rst(rst), .vsync(vs_a), .pause(pause), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .write_en(we_a), .write_addr(wa_a), .pixel_data_in(pix_a), .swap(swap_a), .frame_idx(frame_a), .busy(busy_a));
  frame_writer #(.FRAME_HOLD(1)) u_b (
    .clk(clk), .rst(rst), .vsync(vs_b), .pause(pause), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .write_en(we_b), .write_addr(wa_b), .pixel_data_in(pix_b), .swap(swap_b), .frame_idx(frame_b), .busy(busy_b));

  always_ff @(posedge clk) begin
    rom_data_a <= rom_addr_a[7:0];
    rom_data_b <= rom_addr_b[7:0];
  end

  always @(negedge clk) begin
    if (swap_b) swap_b_cnt++;
    if (!rst) begin
      fill_wr_a = 0; exp_wa_a = 0; swap_prev_a = 1'b0;
    end else begin
      if (swap_a) begin fill_wr_a = 0; first_rom_a = int'(rom_addr_a); swap_a_cnt++; end
      if (swap_a && swap_prev_a) wide_a++;
      if (swap_a && we_a) both_a++;
      swap_prev_a = swap_a;
      if (we_a) begin
        wr_a++; fill_wr_a++;
        if (int'(wa_a) != exp_wa_a || pix_a != wa_a[7:0]) seq_err_a++;
        if (wa_a == 19'd767) last_rom_a = int'(rom_addr_a);
        exp_wa_a = (wa_a == 19'd767) ? 0 : int'(wa_a) + 1;
      end
      if (int'(rom_addr_a) > max_rom_a) max_rom_a = int'(rom_addr_a);
    end
  end

  task automatic pulse(input bit sel);
    @(posedge clk); #1;
    if (sel) vs_b = 1'b0; else vs_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (sel) vs_b = 1'b1; else vs_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (!busy_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    #3;
    if (rom_addr_a !== 12'd0) begin errs++; $display("FAIL rst_rom_addr got=%0d want=0", rom_addr_a); end cmp++;
    if (we_a !== 1'b0) begin errs++; $display("FAIL rst_write_en got=%0d want=0", we_a); end cmp++;
    if (wa_a !== 19'd0) begin errs++; $display("FAIL rst_write_addr got=%0d want=0", wa_a); end cmp++;
    if (pix_a !== 8'd0) begin errs++; $display("FAIL rst_pixel got=%0d want=0", pix_a); end cmp++;
    if (swap_a !== 1'b0) begin errs++; $display("FAIL rst_swap got=%0d want=0", swap_a); end cmp++;
    if (frame_a !== 2'd0) begin errs++; $display("FAIL rst_frame got=%0d want=0", frame_a); end cmp++;
    if (busy_a !== 1'b0) begin errs++; $display("FAIL rst_busy got=%0d want=0", busy_a); end cmp++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_fill;
    int bad = 0, nwr = 0;
    logic busy_end = 1'bx;
    for (int k = 1; k <= 769; k++) begin
      @(posedge clk); #1;
      if (we_a) nwr++;
      if (we_a !== (k <= 768)) bad++;
      if (k <= 768 && (int'(wa_a) != k - 1 || pix_a != 8'(k - 1) || busy_a !== 1'b1)) bad++;
      if (k <= 767 && int'(rom_addr_a) != k) bad++;
      if (k == 769) busy_end = busy_a;
    end
    if (nwr != 768) begin errs++; $display("FAIL fill_writes got=%0d want=768", nwr); end cmp++;
    if (bad != 0) begin errs++; $display("FAIL fill_sequence got=%0d bad cycles want=0", bad); end cmp++;
    if (busy_end !== 1'b0) begin errs++; $display("FAIL fill_busy_fall got=%0d want=0", busy_end); end cmp++;
    if (swap_a_cnt != 0) begin errs++; $display("FAIL fill_no_swap got=%0d want=0", swap_a_cnt); end cmp++;
  endtask

  task automatic test_frame_seq;
    bit ok;
    int s0;
    for (int r = 1; r <= 4; r++) begin
      wait_idle_a(ok);
      if (ok !== 1'b1) begin errs++; $display("FAIL seq_idle_timeout got=%0d want=1", ok); end cmp++;
      s0 = swap_a_cnt;
      repeat (14) pulse(0);
      if (swap_a_cnt != s0) begin errs++; $display("FAIL seq_early_swap got=%0d want=%0d", swap_a_cnt, s0); end cmp++;
      pulse(0);
      if (swap_a_cnt != s0 + 1) begin errs++; $display("FAIL seq_swap got=%0d want=%0d", swap_a_cnt, s0 + 1); end cmp++;
      if (int'(frame_a) != r % 4) begin errs++; $display("FAIL seq_frame got=%0d want=%0d", frame_a, r % 4); end cmp++;
      if (r == 1) begin
        if (first_rom_a != 768) begin errs++; $display("FAIL seq_first_rom got=%0d want=768", first_rom_a); end cmp++;
        wait_idle_a(ok);
        if (last_rom_a != 1535) begin errs++; $display("FAIL seq_last_rom got=%0d want=1535", last_rom_a); end cmp++;
      end
    end
    if (max_rom_a != 3071) begin errs++; $display("FAIL seq_max_rom got=%0d want=3071", max_rom_a); end cmp++;
    if (wide_a != 0) begin errs++; $display("FAIL seq_swap_width got=%0d want=0", wide_a); end cmp++;
    if (both_a != 0) begin errs++; $display("FAIL seq_swap_with_write got=%0d want=0", both_a); end cmp++;
  endtask

  task automatic test_pause;
    bit ok;
    int s0;
    wait_idle_a(ok);
    s0 = swap_a_cnt;
    repeat (14) pulse(0);
    pause = 1'b1;
    pulse(0);
    if (swap_a_cnt != s0) begin errs++; $display("FAIL pause_swap got=%0d want=%0d", swap_a_cnt, s0); end cmp++;
    if (frame_a !== 2'd0) begin errs++; $display("FAIL pause_frame got=%0d want=0", frame_a); end cmp++;
    pause = 1'b0;
    pulse(0);
    if (swap_a_cnt != s0 + 1) begin errs++; $display("FAIL unpause_swap got=%0d want=%0d", swap_a_cnt, s0 + 1); end cmp++;
    if (frame_a !== 2'd1) begin errs++; $display("FAIL unpause_frame got=%0d want=1", frame_a); end cmp++;
  endtask

  task automatic test_midfill;
    bit ok, found = 1'b0;
    int s0 = swap_a_cnt;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (rom_addr_a == 12'd1166) begin found = 1'b1; break; end
    end
    if (found !== 1'b1) begin errs++; $display("FAIL mid_find_pix got=%0d want=1", found); end cmp++;
    vs_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (u_a.vs_edge !== 1'b1 || rom_addr_a !== 12'd1168) begin
      errs++; $display("FAIL mid_edge_at_pix400 got=%0d/%0d want=1/1168", u_a.vs_edge, rom_addr_a);
    end cmp++;
    @(posedge clk); #1 vs_a = 1'b1;
    if (u_a.vs_cnt_q !== 4'd1) begin errs++; $display("FAIL mid_vs_cnt got=%0d want=1", u_a.vs_cnt_q); end cmp++;
    wait_idle_a(ok);
    if (fill_wr_a != 768) begin errs++; $display("FAIL mid_fill_writes got=%0d want=768", fill_wr_a); end cmp++;
    if (swap_a_cnt != s0) begin errs++; $display("FAIL mid_no_swap got=%0d want=%0d", swap_a_cnt, s0); end cmp++;
    if (u_a.vs_cnt_q !== 4'd1) begin errs++; $display("FAIL mid_vs_cnt_end got=%0d want=1", u_a.vs_cnt_q); end cmp++;
    if (seq_err_a != 0) begin errs++; $display("FAIL mid_write_seq got=%0d want=0", seq_err_a); end cmp++;
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    int s0 = swap_a_cnt;
    for (int i = 0; i < 20 && swap_a_cnt == s0; i++) pulse(0);
    if (frame_a !== 2'd2) begin errs++; $display("FAIL rmid_frame2 got=%0d want=2", frame_a); end cmp++;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (rom_addr_a == 12'd1836) begin found = 1'b1; break; end
    end
    if (found !== 1'b1 || we_a !== 1'b1) begin errs++; $display("FAIL rmid_find_pix got=%0d/%0d want=1/1", found, we_a); end cmp++;
    #1 rst = 1'b0;
    #1;
    if ({rom_addr_a, we_a, wa_a, pix_a, swap_a, frame_a, busy_a} !== '0) begin
      errs++; $display("FAIL rmid_async_zero got=rom%0d we%0d wa%0d px%0d sw%0d fr%0d bz%0d want=all0",
                       rom_addr_a, we_a, wa_a, pix_a, swap_a, frame_a, busy_a);
    end cmp++;
    @(negedge clk) rst = 1'b1;
    #1;
    if (frame_a !== 2'd0) begin errs++; $display("FAIL rmid_frame0 got=%0d want=0", frame_a); end cmp++;
    @(posedge clk); #1;
    if (we_a !== 1'b1 || wa_a !== 19'd0 || rom_addr_a !== 12'd1) begin
      errs++; $display("FAIL rmid_restart got=we%0d wa%0d rom%0d want=we1 wa0 rom1", we_a, wa_a, rom_addr_a);
    end cmp++;
  endtask

  task automatic test_hold1_drain;
    int s0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (766) @(posedge clk);
    #1 vs_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (u_b.vs_edge !== 1'b1 || busy_b !== 1'b1 || we_b !== 1'b1 || wa_b !== 19'd767) begin
      errs++; $display("FAIL drain_edge_align got=edge%0d busy%0d we%0d wa%0d want=1 1 1 767", u_b.vs_edge, busy_b, we_b, wa_b);
    end cmp++;
    s0 = swap_b_cnt;
    vs_b = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    if (swap_b_cnt != s0) begin errs++; $display("FAIL drain_edge_swap got=%0d want=%0d", swap_b_cnt, s0); end cmp++;
    if (u_b.vs_cnt_q !== 1'b1) begin errs++; $display("FAIL drain_vs_cnt got=%0d want=1", u_b.vs_cnt_q); end cmp++;
    if (busy_b !== 1'b0) begin errs++; $display("FAIL drain_busy got=%0d want=0", busy_b); end cmp++;
    pulse(1);
    if (swap_b_cnt != s0 + 1) begin errs++; $display("FAIL hold1_next_swap got=%0d want=%0d", swap_b_cnt, s0 + 1); end cmp++;
    if (frame_b !== 2'd1) begin errs++; $display("FAIL hold1_frame got=%0d want=1", frame_b); end cmp++;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_frame_seq;
    test_pause;
    test_midfill;
    test_reset_mid;
    test_hold1_drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
